cpu_run_ctrl: RTL and testbench

- Synthesizable run controller and register-write tracer for the single-cycle cpu; generalises the fixed "reset, run N cycles, finish, dump regb[1]" bring-up flow into reusable hardware.
- Sequences the CPU's reset, runs it for a programmable number of cycles, then holds it.
- Captures writes to a watched register-file entry into a trace FIFO that a host, bench or debug port can read.

---
 rtl/cpu_run_ctrl_if.sv | 41 ++++
 rtl/cpu_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle of cpu_run_ctrl: run control, register-write snoop and trace read port.
// master = host/bench side, slave = the run controller.
interface cpu_run_ctrl_if #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int CNT_W       = 16,
   parameter int TRACE_DEPTH = 8
);
   localparam int TC_W = $clog2(TRACE_DEPTH) + 1;

   logic              start;
   logic              stop;
   logic [CNT_W-1:0]  max_cycles;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  cycle_cnt;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              tr_rd;
   logic [DATA_W-1:0] tr_data;
   logic [CNT_W-1:0]  tr_cycle;
   logic [ADDR_W-1:0] tr_addr;
   logic              tr_empty;
   logic              tr_full;
   logic [TC_W-1:0]   tr_count;
   logic              tr_ovf;

   modport master (
      output start, stop, max_cycles, rf_we, rf_waddr, rf_wdata, tr_rd,
      input  cpu_rst, busy, done, cycle_cnt,
      input  tr_data, tr_cycle, tr_addr, tr_empty, tr_full, tr_count, tr_ovf
   );

   modport slave (
      input  start, stop, max_cycles, rf_we, rf_waddr, rf_wdata, tr_rd,
      output cpu_rst, busy, done, cycle_cnt,
      output tr_data, tr_cycle, tr_addr, tr_empty, tr_full, tr_count, tr_ovf
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle cpu: reset sequencing, bounded run, register-write trace FIFO.
// Optional macro CPU_RUN_CTRL_TRACE_ALL_EN: trace every non-zero register write instead of WATCH_REG only.
module cpu_run_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int CNT_W       = 16,
   parameter int RST_CYCLES  = 2,
   parameter int TRACE_DEPTH = 8,
   parameter int WATCH_REG   = 1
) (
   input logic           clk,
   input logic           reset,
   cpu_run_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int RC_W  = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  limit_q, limit_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [RC_W-1:0]   rc_q, rc_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] mem_data [TRACE_DEPTH];
   logic [CNT_W-1:0]  mem_cyc  [TRACE_DEPTH];
`ifdef CPU_RUN_CTRL_TRACE_ALL_EN
   logic [ADDR_W-1:0] mem_addr [TRACE_DEPTH];
`endif

   logic start_acc, lim_hit, cap, pop, wr_en, empty, full;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
   // Compare one bit wider so limit = all-ones still terminates.
   assign lim_hit   = (limit_q != '0) &&
                      (({1'b0, cyc_q} + (CNT_W+1)'(1)) == {1'b0, limit_q});

`ifdef CPU_RUN_CTRL_TRACE_ALL_EN
   assign cap = (state_q == S_RUN) && bus.rf_we && (bus.rf_waddr != '0);
`else
   assign cap = (state_q == S_RUN) && bus.rf_we && (bus.rf_waddr == ADDR_W'(WATCH_REG));
`endif

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (PTR_W+1)'(TRACE_DEPTH));
   assign pop   = bus.tr_rd && !empty;
   assign wr_en = cap && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE,
         S_DONE:  if (bus.start) state_d = S_RESET;
         S_RESET: if (rc_q == RC_W'(1)) state_d = S_RUN;
         S_RUN:   if (bus.stop || lim_hit) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cpu_rst = 1'b1;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      case (state_q)
         S_RESET: bus.busy = 1'b1;
         S_RUN: begin
            bus.cpu_rst = 1'b0;
            bus.busy    = 1'b1;
         end
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      limit_d = limit_q;
      cyc_d   = cyc_q;
      rc_d    = rc_q;
      if (start_acc) begin
         limit_d = bus.max_cycles;
         cyc_d   = '0;
         rc_d    = RC_W'(RST_CYCLES);
      end else if (state_q == S_RESET) begin
         rc_d = rc_q - RC_W'(1);
      end else if (state_q == S_RUN) begin
         cyc_d = sat_inc(cyc_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         limit_q <= '0;
         cyc_q   <= '0;
         rc_q    <= '0;
      end else begin
         limit_q <= limit_d;
         cyc_q   <= cyc_d;
         rc_q    <= rc_d;
      end
   end

   // A push into a full FIFO survives only when a pop frees the slot in the same cycle.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (start_acc) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (cap && !wr_en) ovf_d = 1'b1;
         if (wr_en) wr_d = wr_q + PTR_W'(1);
         if (pop)   rd_d = rd_q + PTR_W'(1);
         if (wr_en && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
         else if (pop && !wr_en) cnt_d = cnt_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_q] <= bus.rf_wdata;
         mem_cyc[wr_q]  <= cyc_q;
`ifdef CPU_RUN_CTRL_TRACE_ALL_EN
         mem_addr[wr_q] <= bus.rf_waddr;
`endif
      end
   end

   assign bus.tr_data  = empty ? '0 : mem_data[rd_q];
   assign bus.tr_cycle = empty ? '0 : mem_cyc[rd_q];
`ifdef CPU_RUN_CTRL_TRACE_ALL_EN
   assign bus.tr_addr  = empty ? '0 : mem_addr[rd_q];
`else
   assign bus.tr_addr  = empty ? '0 : ADDR_W'(WATCH_REG);
`endif
   assign bus.tr_empty  = empty;
   assign bus.tr_full   = full;
   assign bus.tr_count  = cnt_q;
   assign bus.tr_ovf    = ovf_q;
   assign bus.cycle_cnt = cyc_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: bounded run with trace, overflow, stop, restart and async reset.
module tb_cpu_run_ctrl;
   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 5;
   localparam int CNT_W       = 16;
   localparam int TRACE_DEPTH = 8;
`ifdef CPU_RUN_CTRL_TRACE_ALL_EN
   localparam int ALL = 1;
`else
   localparam int ALL = 0;
`endif

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] v;
   } chk_t;

   logic clk = 1'b0;
   logic reset;

   cpu_run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                     .TRACE_DEPTH(TRACE_DEPTH)) bus ();

   cpu_run_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_CYCLES(2),
                  .TRACE_DEPTH(TRACE_DEPTH), .WATCH_REG(1)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   chk_t        st_q[$];
   logic [52:0] tr_q[$];
   chk_t        mc;
   logic [52:0] me;
   logic [63:0] act;
   int          total = 0;
   int          bad   = 0;
   logic        snap  = 1'b0;
   logic        fin   = 1'b0;

   int          wk[8], wa[8], wc[8];
   logic [31:0] wd[8];
   int          nw;
   int          vis, pend;

   function automatic logic [63:0] mk_st(bit r, bit b, bit d, bit e, bit f, bit o, int n, int c);
      return {38'd0, r, b, d, e, f, o, 4'(n), 16'(c)};
   endfunction

   function automatic logic [63:0] observe(int kind);
      if (kind == 0)
         return {38'd0, bus.cpu_rst, bus.busy, bus.done, bus.tr_empty, bus.tr_full,
                 bus.tr_ovf, bus.tr_count, bus.cycle_cnt};
      return {11'd0, bus.tr_data, bus.tr_cycle, bus.tr_addr};
   endfunction

   task automatic expect_st(string name, logic [63:0] v);
      st_q.push_back('{name, 0, v});
   endtask

   task automatic expect_head(string name, logic [52:0] v);
      st_q.push_back('{name, 1, {11'd0, v}});
   endtask

   task automatic sample();
      snap = 1'b1;
      @(negedge clk);
      #1 snap = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: status snapshots on request, trace entries whenever the DUT pops one.
   always @(negedge clk) begin
      if (snap) begin
         while (st_q.size() > 0) begin
            mc  = st_q.pop_front();
            act = observe(mc.kind);
            total++;
            if (act !== mc.v) begin
               bad++;
               $display("FAIL %s: got %h expected %h", mc.name, act, mc.v);
            end
         end
      end
      if (bus.tr_rd && !bus.tr_empty) begin
         total++;
         if (tr_q.size() == 0) begin
            bad++;
            $display("FAIL trace_pop: got %h expected no entry",
                     {bus.tr_data, bus.tr_cycle, bus.tr_addr});
         end else begin
            me = tr_q.pop_front();
            if ({bus.tr_data, bus.tr_cycle, bus.tr_addr} !== me) begin
               bad++;
               $display("FAIL trace_entry: got %h expected %h",
                        {bus.tr_data, bus.tr_cycle, bus.tr_addr}, me);
            end
         end
      end
      if (fin) begin
         total++;
         if (tr_q.size() != 0) begin
            bad++;
            $display("FAIL trace_left: got %0d unread expected 0", tr_q.size());
         end
         total++;
         if (st_q.size() != 0) begin
            bad++;
            $display("FAIL status_left: got %0d pending expected 0", st_q.size());
         end
      end
   end

   // Start a run of maxc cycles and check every cycle; iteration k follows the k-th edge after acceptance.
   task automatic run_check(string tag, int maxc, int nk);
      bit in_run;
      int cnt;
      tick();
      bus.start      = 1'b1;
      bus.max_cycles = 16'(maxc);
      tr_q.delete();
      vis  = 0;
      pend = 0;
      for (int k = 0; k < nk; k++) begin
         tick();
         bus.start = 1'b0;
         bus.rf_we = 1'b0;
         vis += pend;
         pend = 0;
         for (int w = 0; w < nw; w++) begin
            if (wk[w] == k) begin
               bus.rf_we    = 1'b1;
               bus.rf_waddr = 5'(wa[w]);
               bus.rf_wdata = wd[w];
               if (wc[w] != 0) begin
                  pend = 1;
                  tr_q.push_back({wd[w], 16'(k - 2), 5'(wa[w])});
               end
            end
         end
         in_run = (k >= 2) && (k < maxc + 2);
         cnt    = (k < 2) ? 0 : (in_run ? k - 2 : maxc);
         expect_st($sformatf("%s_k%0d", tag, k),
                   mk_st(!in_run, k < maxc + 2, k >= maxc + 2, vis == 0, 1'b0, 1'b0, vis, cnt));
         sample();
      end
      bus.rf_we = 1'b0;
   endtask

   initial begin
      reset          = 1'b0;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.max_cycles = '0;
      bus.rf_we      = 1'b0;
      bus.rf_waddr   = '0;
      bus.rf_wdata   = '0;
      bus.tr_rd      = 1'b0;

      tick();
      expect_st("reset_state", mk_st(1, 0, 0, 1, 0, 0, 0, 0));
      expect_head("reset_head", 53'd0);
      sample();
      tick();
      reset = 1'b1;
      expect_st("idle", mk_st(1, 0, 0, 1, 0, 0, 0, 0));
      sample();

      // 9-cycle run; writes in RESET, to reg 0, and in DONE must not be traced.
      nw = 7;
      wk = '{1, 4, 6, 7, 8, 9, 11, 0};
      wa = '{1, 1, 1, 3, 0, 1, 1, 0};
      wd = '{32'hDEAD, 32'h5, 32'hA, 32'h33, 32'h77, 32'hF, 32'hBEEF, 32'h0};
      wc = '{0, 1, 1, ALL, 0, 1, 0, 0};
      run_check("run9", 9, 13);
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.tr_rd = 1'b1;
      end
      tick();
      bus.tr_rd = 1'b0;
      expect_st("run9_drained", mk_st(1, 0, 1, 1, 0, 0, 0, 9));
      expect_head("drained_head", 53'd0);
      sample();

      // Unbounded run: overflow, push+pop while full, ignored start, stop at 20.
      tick();
      bus.start      = 1'b1;
      bus.max_cycles = '0;
      tr_q.delete();
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.rf_we      = 1'b1;
         bus.rf_waddr   = 5'd1;
         bus.rf_wdata   = 32'(256 + i);
         bus.start      = (i == 5);
         bus.max_cycles = (i == 5) ? 16'd2 : 16'd0;
         if (i < 8) tr_q.push_back({32'(256 + i), 16'(i), 5'd1});
      end
      tick();
      bus.start    = 1'b0;
      bus.rf_wdata = 32'h1AA;
      bus.tr_rd    = 1'b1;
      tr_q.push_back({32'h1AA, 16'd10, 5'd1});
      expect_st("ovf_full", mk_st(0, 1, 0, 0, 1, 1, 8, 10));
      sample();
      tick();
      bus.rf_we = 1'b0;
      bus.tr_rd = 1'b0;
      expect_st("ovf_pushpop", mk_st(0, 1, 0, 0, 1, 1, 8, 11));
      expect_head("ovf_head", {32'h101, 16'd1, 5'd1});
      sample();
      for (int c = 12; c <= 20; c++) begin
         tick();
         bus.stop = (c == 20);
      end
      tick();
      bus.stop = 1'b0;
      expect_st("stop_done", mk_st(1, 0, 1, 0, 1, 1, 8, 21));
      sample();
      for (int i = 0; i < 6; i++) begin
         tick();
         bus.tr_rd = 1'b1;
      end
      tick();
      bus.tr_rd = 1'b0;
      expect_st("partial_read", mk_st(1, 0, 1, 0, 0, 1, 2, 21));
      sample();

      // Restart from DONE with two entries held: trace and overflow flag cleared.
      nw = 0;
      run_check("restart4", 4, 8);

      // Asynchronous reset in the middle of a run.
      tick();
      bus.start      = 1'b1;
      bus.max_cycles = '0;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      bus.rf_we    = 1'b1;
      bus.rf_waddr = 5'd1;
      bus.rf_wdata = 32'h99;
      tr_q.push_back({32'h99, 16'd1, 5'd1});
      tick();
      bus.rf_we = 1'b0;
      expect_st("pre_areset", mk_st(0, 1, 0, 0, 0, 0, 1, 2));
      sample();
      tick();
      reset = 1'b0;
      tr_q.delete();
      expect_st("async_reset", mk_st(1, 0, 0, 1, 0, 0, 0, 0));
      expect_head("async_head", 53'd0);
      sample();
      tick();
      reset = 1'b1;
      tick();

      fin = 1'b1;
      @(negedge clk);
      #1 fin = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
